// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master modport is the loader side; slave is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a COUNT/DATA/CHK byte frame,
// writes big-endian words to consecutive addresses and holds the CPU until verified.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERR
  } state_t;

  localparam logic [16:0]     MAX_COUNT = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

  state_t          state;
  logic [7:0]      count_hi;
  logic [ADDR_W:0] word_idx;
  logic [ADDR_W:0] last_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      acc;
  logic [23:0]     shift_reg;

  logic            xfer;
  logic [15:0]     hdr_count;
  logic            header_bad;

  assign xfer       = bus.in_valid && bus.in_ready;
  assign hdr_count  = {count_hi, bus.in_data};
  assign header_bad = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_COUNT);

  // Ready is a pure state decode so it drops in the same cycle the state leaves a receiving state.
  assign bus.in_ready = (state == HDR_HI) || (state == HDR_LO) ||
                        (state == DATA)   || (state == CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count_hi      <= '0;
      word_idx      <= '0;
      last_idx      <= '0;
      byte_idx      <= '0;
      acc           <= '0;
      shift_reg     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR_HI;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            count_hi <= bus.in_data;
            state    <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            if (header_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state    <= DATA;
              last_idx <= (ADDR_W+1)'(hdr_count - 16'd1);
              word_idx <= '0;
              byte_idx <= '0;
              acc      <= '0;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            acc      <= acc ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes the word; the write is issued without stalling the stream.
            if (byte_idx == 2'd3) begin
              bus.mem_wdata <= {shift_reg, bus.in_data};
              bus.mem_addr  <= word_idx[ADDR_W-1:0];
              bus.mem_we    <= 1'b1;
              word_idx      <= word_idx + IDX_ONE;
              if (word_idx == last_idx) state <= CHECK;
            end else begin
              shift_reg <= {shift_reg[15:0], bus.in_data};
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            if (bus.in_data == acc) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: a frame parser model predicts writes
// and final status; a negedge monitor pops expected writes as mem_we pulses appear.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          last_wr_addr = -1;
  wr_t         exp_q[$];
  logic [7:0]  frame_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
        checkOutput("wr_data", bus.mem_wdata, w.data);
      end
      last_wr_addr = int'(bus.mem_addr);
    end
    if (done === 1'b1 || error === 1'b1)
      checkOutput("ready_when_finished", 32'(bus.in_ready), 32'd0);
  end

  // Reference model: parse the frame by its rules and predict writes and outcome.
  task automatic modelFrame(output bit exp_done, output bit exp_err);
    int         count;
    logic [7:0] chk;
    logic [31:0] w;
    count    = int'({frame_q[0], frame_q[1]});
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (count == 0 || count > DEPTH) return;
    chk = 8'h00;
    for (int n = 0; n < count; n++) begin
      w = {frame_q[2+4*n], frame_q[3+4*n], frame_q[4+4*n], frame_q[5+4*n]};
      exp_q.push_back('{n, w});
      chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    if (frame_q[2+4*count] == chk) begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end
  endtask

  task automatic buildRandom(input int count, input bit bad_chk);
    logic [7:0] chk;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(count >> 8));
    frame_q.push_back(8'(count));
    chk = 8'h00;
    for (int i = 0; i < 4*count; i++) begin
      b = 8'($urandom_range(255));
      frame_q.push_back(b);
      chk = chk ^ b;
    end
    if (bad_chk) chk = chk ^ 8'($urandom_range(1, 255));
    frame_q.push_back(chk);
  endtask

  task automatic setCase1(input logic [7:0] chk);
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, chk};
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams the first n_bytes of frame_q; returns on the negedge after the last transfer.
  task automatic applyStimulus(input int gap_pct, input int start_at, input int n_bytes);
    int idx    = 0;
    int cycles = 0;
    bit pulsed = 1'b0;
    while (idx < n_bytes) begin
      @(negedge clk);
      bus.in_data  = frame_q[idx];
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      start        = (!pulsed && idx == start_at);
      if (start) pulsed = 1'b1;
      if (bus.in_valid && bus.in_ready) idx++;
      cycles++;
      if (cycles > 20*n_bytes + 50) begin
        checkOutput("stream_timeout", 32'(idx), 32'(n_bytes));
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic checkResult(input bit exp_done, input bit exp_err);
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("error", 32'(error), 32'(exp_err));
    checkOutput("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    checkOutput("in_ready_after", 32'(bus.in_ready), 32'd0);
    checkOutput("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic runFrame(input int gap_pct, input int start_at);
    bit exp_done, exp_err;
    modelFrame(exp_done, exp_err);
    applyStimulus(gap_pct, start_at, frame_q.size());
    checkResult(exp_done, exp_err);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Case 1: two words, correct checksum, no gaps
    pulseStart();
    setCase1(8'h2A);
    runFrame(0, -1);

    // Case 2: bad checksum, then recovery
    pulseStart();
    setCase1(8'h2B);
    runFrame(0, -1);
    pulseStart();
    checkOutput("err_cleared", 32'(error), 32'd0);
    setCase1(8'h2A);
    runFrame(0, -1);

    // Case 3: header boundaries
    pulseStart();
    frame_q = '{8'h00, 8'h00};
    runFrame(0, -1);
    pulseStart();
    frame_q = '{8'h04, 8'h01};
    runFrame(0, -1);
    pulseStart();
    buildRandom(DEPTH, 1'b0);
    runFrame(0, -1);
    checkOutput("last_addr_full", 32'(last_wr_addr), 32'(DEPTH-1));

    // Case 4: gaps and randomised frames
    pulseStart();
    setCase1(8'h2A);
    runFrame(30, -1);
    for (int t = 0; t < 8; t++) begin
      pulseStart();
      buildRandom($urandom_range(1, 6), ($urandom_range(3) == 0));
      runFrame(30, -1);
    end

    // Case 5: reset after the fifth data byte
    pulseStart();
    setCase1(8'h2A);
    begin
      bit d0, e0;
      modelFrame(d0, e0);
    end
    applyStimulus(0, -1, 7);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("writes_before_reset", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    checkResetValues();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues();
    pulseStart();
    setCase1(8'h2A);
    runFrame(0, -1);

    // Case 6: start during DATA is ignored; start during DONE restarts
    pulseStart();
    buildRandom(3, 1'b0);
    runFrame(0, 6);
    pulseStart();
    checkOutput("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("restart_done", 32'(done), 32'd0);
    buildRandom(2, 1'b0);
    runFrame(10, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
